// File: rtl/bin_to_bcd_disp.sv
// bin_to_bcd_disp: serial double-dabble converter producing eight blanked/signed display digit codes
module bin_to_bcd_disp #(
  parameter logic [3:0] BLANK_CODE = 4'd10,
  parameter logic [3:0] DASH_CODE  = 4'd11,
  parameter bit         LZ_BLANK   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        neg_in,
  input  logic [26:0] value_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bit_7,
  output logic [3:0]  bit_6,
  output logic [3:0]  bit_5,
  output logic [3:0]  bit_4,
  output logic [3:0]  bit_3,
  output logic [3:0]  bit_2,
  output logic [3:0]  bit_1,
  output logic [3:0]  bit_0
);
  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;
  state_t      state;
  logic [26:0] shift;
  logic [31:0] bcd, adj, fmt, disp;
  logic [4:0]  cnt;
  logic [2:0]  msd;
  logic        neg, ovf, nz;
  assign {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0} = disp;
  always_comb begin
    adj = '0;
    for (int i = 0; i < 8; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // msd stays 0 for a zero value so the units digit is always shown
  always_comb begin
    msd = '0;
    fmt = '0;
    nz  = |bcd;
    for (int i = 0; i < 8; i++)
      if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    for (int i = 0; i < 8; i++)
      fmt[4*i +: 4] = ovf ? DASH_CODE :
                      LZ_BLANK ? ((neg && nz && i == int'(msd) + 1) ? DASH_CODE :
                                  (i > int'(msd) ? BLANK_CODE : bcd[4*i +: 4])) :
                      ((neg && nz && i == 7) ? DASH_CODE : bcd[4*i +: 4]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      disp  <= {8{BLANK_CODE}};
      shift <= '0;
      bcd   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift <= value_in;
            neg   <= neg_in;
            ovf   <= (value_in > 27'd99_999_999) || (neg_in && value_in > 27'd9_999_999);
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= {adj[30:0], shift[26]};
          shift <= {shift[25:0], 1'b0};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd26) state <= FMT;
        end
        FMT: begin
          disp  <= fmt;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_disp.sv
// tb_bin_to_bcd_disp: directed and random conversions checked against an arithmetic digit model
module tb_bin_to_bcd_disp;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, neg_in = 1'b0;
  logic [26:0] value_in = '0;
  logic        busy, done;
  logic [3:0]  b7, b6, b5, b4, b3, b2, b1, b0;
  logic [31:0] disp;
  int total = 0, bad = 0;
  assign disp = {b7, b6, b5, b4, b3, b2, b1, b0};
  always #10 clk = ~clk;
  bin_to_bcd_disp dut (
    .clk(clk), .rst(rst), .start(start), .neg_in(neg_in), .value_in(value_in),
    .busy(busy), .done(done),
    .bit_7(b7), .bit_6(b6), .bit_5(b5), .bit_4(b4),
    .bit_3(b3), .bit_2(b2), .bit_1(b1), .bit_0(b0)
  );
  function automatic logic [31:0] model(input logic n, input int v);
    logic [31:0] r;
    int nd, t;
    r = '0;
    if (v > 99_999_999 || (n && v > 9_999_999)) return {8{4'd11}};
    nd = 1;
    t = v / 10;
    while (t != 0) begin nd++; t /= 10; end
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = (i < nd) ? 4'(t % 10) : 4'd10;
      t /= 10;
    end
    if (n && v != 0) r[4*nd +: 4] = 4'd11;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic n, input int v);
    start = 1'b1;
    neg_in = n;
    value_in = 27'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  // inj > 0 pulses a second start after that many busy cycles
  task automatic wait_done(input string tag, input int inj, input logic [31:0] prev);
    int k, nb;
    logic held;
    k = 0; nb = 0; held = 1'b1;
    do begin
      if (k == inj) begin
        start = 1'b1;
        value_in = 27'($urandom_range(0, 99_999_999));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (!done) begin
        if (busy) nb++;
        if (disp !== prev) held = 1'b0;
      end
    end while (!done && k < 40);
    chk({tag, "_lat"}, 32'(k), 32'd28);
    chk({tag, "_busy"}, 32'(nb), 32'd27);
    chk({tag, "_hold"}, {31'd0, held}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask
  task automatic run(input string tag, input logic n, input int v, input int inj);
    logic [31:0] prev;
    prev = disp;
    launch(n, v);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    wait_done(tag, inj, prev);
    chk({tag, "_disp"}, disp, model(n, v));
  endtask
  initial begin
    int k;
    logic n;
    int v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp", disp, {8{4'd10}});
    chk("rst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_flags", {30'd0, busy, done}, 32'd0);
    run("d12345678", 1'b0, 12_345_678, -1);
    chk("d12345678_lit", disp, 32'h1234_5678);
    run("n305", 1'b1, 305, -1);
    chk("n305_lit", disp, 32'hAAAA_B305);
    run("n0", 1'b1, 0, -1);
    chk("n0_lit", disp, 32'hAAAA_AAA0);
    run("ovf100m", 1'b0, 100_000_000, -1);
    chk("ovf100m_lit", disp, 32'hBBBB_BBBB);
    run("ovfneg10m", 1'b1, 10_000_000, -1);
    run("n9999999", 1'b1, 9_999_999, -1);
    chk("n9999999_lit", disp, 32'hB999_9999);
    run("p99999999", 1'b0, 99_999_999, -1);
    run("pmax", 1'b0, 134_217_727, -1);
    run("ignore2nd", 1'b0, 4_096, 5);
    @(posedge clk);
    #1;
    chk("ignore2nd_single", {30'd0, busy, done}, 32'd0);
    // back-to-back: second start issued while done is high
    launch(1'b1, 42);
    chk("b2b_a_busy0", {31'd0, busy}, 32'd1);
    wait_done("b2b_a", -1, disp);
    chk("b2b_a_disp", disp, model(1'b1, 42));
    run("b2b_b", 1'b0, 7_654_321, -1);
    for (int r = 0; r < 12; r++) begin
      n = 1'($urandom_range(0, 1));
      v = (r % 3 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 134_217_727));
      run("rnd", n, v, -1);
    end
    // asynchronous reset mid-conversion
    launch(1'b0, 55_555);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_disp", disp, {8{4'd10}});
    chk("midrst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) k++;
    end
    chk("midrst_nodone", 32'(k), 32'd0);
    chk("midrst_hold", disp, {8{4'd10}});
    run("post_rst", 1'b1, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
